// File: rtl/uart_cmd_pkg.sv
// Shared states, frame constants and payload type for uart_cmd_ctrl.
// The GET_CHK state exists only when UART_CMD_CHECKSUM_EN is defined.
package uart_cmd_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned LED_W  = 4;

  localparam logic [BYTE_W-1:0] SYNC_BYTE   = 8'hA5;
  localparam logic [BYTE_W-1:0] CMD_DISPLAY = 8'h01;
  localparam logic [BYTE_W-1:0] CMD_LED     = 8'h02;
  localparam logic [BYTE_W-1:0] CMD_CLEAR   = 8'h03;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_GET_CMD  = 2'd1,
    ST_GET_DATA = 2'd2
`ifdef UART_CMD_CHECKSUM_EN
    ,
    ST_GET_CHK  = 2'd3
`endif
  } state_e;

  typedef struct packed {
    logic [BYTE_W-1:0] cmd;
    logic [BYTE_W-1:0] data;
  } frame_t;

  // Expected CHK byte for a latched frame.
  function automatic logic [BYTE_W-1:0] frame_chk(input frame_t f);
    return f.cmd ^ f.data;
  endfunction

endpackage

// File: rtl/uart_cmd_timer.sv
// Inter-byte timeout counter; saturates at TIMEOUT_CLKS-1 so it never wraps.
module uart_cmd_timer #(
  parameter int unsigned TIMEOUT_CLKS = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CNT_W = (TIMEOUT_CLKS > 2) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CLKS - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != CNT_MAX)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // expired is registered alongside the count so it tracks count_q == CNT_MAX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      expired <= 1'b0;
    end else begin
      count_q <= count_d;
      expired <= (count_d == CNT_MAX);
    end
  end

endmodule

// File: rtl/uart_cmd_ctrl.sv
// UART command frame decoder: SYNC, CMD, DATA [, CHK] drives display and LEDs.
// Define UART_CMD_CHECKSUM_EN to require and verify the trailing CHK byte.
module uart_cmd_ctrl
  import uart_cmd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CLKS = 250000
) (
  input  logic              i_Clk,
  input  logic              i_Rst_L,
  input  logic              i_RX_DV,
  input  logic [BYTE_W-1:0] i_RX_Byte,
  output logic [BYTE_W-1:0] o_Display_Byte,
  output logic [LED_W-1:0]  o_LED,
  output logic              o_Frame_Valid,
  output logic              o_Frame_Error,
  output logic              o_Busy
);

  logic [1:0] rst_sync_q;
  logic       rst_n;

  state_e            state_q, state_d;
  frame_t            frame_q, frame_d;
  frame_t            exec_frame;
  logic              exec_req;
  logic [BYTE_W-1:0] disp_d;
  logic [LED_W-1:0]  led_d;
  logic              valid_d;
  logic              error_d;
  logic              busy_d;
  logic              expired;

  // Asynchronous assertion, release synchronised to i_Clk.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      rst_sync_q <= '0;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_n = rst_sync_q[1];

  uart_cmd_timer #(
    .TIMEOUT_CLKS(TIMEOUT_CLKS)
  ) u_timer (
    .clk    (i_Clk),
    .rst_n  (rst_n),
    .clear  (i_RX_DV || (state_q == ST_IDLE)),
    .enable (state_q != ST_IDLE),
    .expired(expired)
  );

  always_comb begin
    state_d    = state_q;
    frame_d    = frame_q;
    disp_d     = o_Display_Byte;
    led_d      = o_LED;
    valid_d    = 1'b0;
    error_d    = 1'b0;
    exec_req   = 1'b0;
    exec_frame = frame_q;

    if (i_RX_DV) begin
      case (state_q)
        ST_IDLE: begin
          if (i_RX_Byte == SYNC_BYTE) begin
            state_d = ST_GET_CMD;
          end
        end
        ST_GET_CMD: begin
          frame_d.cmd = i_RX_Byte;
          state_d     = ST_GET_DATA;
        end
        ST_GET_DATA: begin
          frame_d.data = i_RX_Byte;
`ifdef UART_CMD_CHECKSUM_EN
          state_d = ST_GET_CHK;
`else
          state_d         = ST_IDLE;
          exec_req        = 1'b1;
          exec_frame.data = i_RX_Byte;
`endif
        end
`ifdef UART_CMD_CHECKSUM_EN
        ST_GET_CHK: begin
          state_d = ST_IDLE;
          if (i_RX_Byte == frame_chk(frame_q)) begin
            exec_req = 1'b1;
          end else begin
            error_d = 1'b1;
          end
        end
`endif
        default: state_d = ST_IDLE;
      endcase
    end else if ((state_q != ST_IDLE) && expired) begin
      // A byte on the expiry cycle takes the branch above instead.
      state_d = ST_IDLE;
      error_d = 1'b1;
    end

    // Execute lands on the same edge that samples the final byte.
    if (exec_req) begin
      case (exec_frame.cmd)
        CMD_DISPLAY: begin
          disp_d  = exec_frame.data;
          valid_d = 1'b1;
        end
        CMD_LED: begin
          led_d   = exec_frame.data[LED_W-1:0];
          valid_d = 1'b1;
        end
        CMD_CLEAR: begin
          disp_d  = '0;
          led_d   = '0;
          valid_d = 1'b1;
        end
        default: error_d = 1'b1;
      endcase
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge i_Clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      frame_q        <= '0;
      o_Display_Byte <= '0;
      o_LED          <= '0;
      o_Frame_Valid  <= 1'b0;
      o_Frame_Error  <= 1'b0;
      o_Busy         <= 1'b0;
    end else begin
      state_q        <= state_d;
      frame_q        <= frame_d;
      o_Display_Byte <= disp_d;
      o_LED          <= led_d;
      o_Frame_Valid  <= valid_d;
      o_Frame_Error  <= error_d;
      o_Busy         <= busy_d;
    end
  end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed bench for uart_cmd_ctrl; frames include CHK only when
// UART_CMD_CHECKSUM_EN is defined.
module tb_uart_cmd_ctrl;

  localparam int unsigned TMO = 16;

  logic       i_Clk = 1'b0;
  logic       i_Rst_L;
  logic       i_RX_DV;
  logic [7:0] i_RX_Byte;
  logic [7:0] o_Display_Byte;
  logic [3:0] o_LED;
  logic       o_Frame_Valid;
  logic       o_Frame_Error;
  logic       o_Busy;

  int n_checks = 0;
  int n_pass   = 0;
  int n_valid  = 0;
  int n_err    = 0;
  int n_both   = 0;
  int v0, e0;

  typedef struct {
    logic [7:0] cmd;
    logic [7:0] data;
    logic [7:0] chk;
    logic       exp_valid;
    logic       exp_error;
    logic [7:0] exp_disp;
    logic [3:0] exp_led;
  } vec_t;

  vec_t vecs[$];

  uart_cmd_ctrl #(.TIMEOUT_CLKS(TMO)) dut (
    .i_Clk         (i_Clk),
    .i_Rst_L       (i_Rst_L),
    .i_RX_DV       (i_RX_DV),
    .i_RX_Byte     (i_RX_Byte),
    .o_Display_Byte(o_Display_Byte),
    .o_LED         (o_LED),
    .o_Frame_Valid (o_Frame_Valid),
    .o_Frame_Error (o_Frame_Error),
    .o_Busy        (o_Busy)
  );

  always #5 i_Clk = ~i_Clk;

  // Pulse counters, sampled at the edge after the pulse is visible.
  always @(posedge i_Clk) begin
    if (o_Frame_Valid) n_valid++;
    if (o_Frame_Error) n_err++;
    if (o_Frame_Valid && o_Frame_Error) n_both++;
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge i_Clk);
  endtask

  // Called at a falling edge; returns at the falling edge after the sampling edge.
  task automatic send_byte(input logic [7:0] b);
    i_RX_DV   = 1'b1;
    i_RX_Byte = b;
    @(negedge i_Clk);
    i_RX_DV   = 1'b0;
    i_RX_Byte = 8'h00;
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [7:0] data, input logic [7:0] chk);
    send_byte(8'hA5);
    send_byte(cmd);
    send_byte(data);
`ifdef UART_CMD_CHECKSUM_EN
    send_byte(chk);
`else
    if (chk == 8'hFF) idle(0);
`endif
  endtask

  initial begin
    i_Rst_L   = 1'b0;
    i_RX_DV   = 1'b0;
    i_RX_Byte = 8'h00;
    idle(3);

    check("reset display", o_Display_Byte, 8'h00);
    check("reset led", 8'(o_LED), 8'h00);
    check("reset valid", 8'(o_Frame_Valid), 8'h00);
    check("reset error", 8'(o_Frame_Error), 8'h00);
    check("reset busy", 8'(o_Busy), 8'h00);

    i_Rst_L = 1'b1;
    idle(3);

    // Non-SYNC bytes in IDLE are dropped silently.
    e0 = n_err;
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h3C);
    idle(2);
    check("idle junk error count", 8'(n_err - e0), 8'h00);
    check("idle junk busy", 8'(o_Busy), 8'h00);

    vecs.push_back('{8'h01, 8'h3C, 8'h3D, 1'b1, 1'b0, 8'h3C, 4'h0});
    vecs.push_back('{8'h02, 8'hF9, 8'hFB, 1'b1, 1'b0, 8'h3C, 4'h9});
`ifdef UART_CMD_CHECKSUM_EN
    vecs.push_back('{8'h01, 8'h77, 8'h00, 1'b0, 1'b1, 8'h3C, 4'h9});
`endif
    vecs.push_back('{8'h07, 8'h00, 8'h07, 1'b0, 1'b1, 8'h3C, 4'h9});
    vecs.push_back('{8'hA5, 8'h00, 8'hA5, 1'b0, 1'b1, 8'h3C, 4'h9});
    vecs.push_back('{8'h03, 8'h00, 8'h03, 1'b1, 1'b0, 8'h00, 4'h0});
    vecs.push_back('{8'h01, 8'hA5, 8'hA4, 1'b1, 1'b0, 8'hA5, 4'h0});
    vecs.push_back('{8'h02, 8'hA5, 8'hA7, 1'b1, 1'b0, 8'hA5, 4'h5});

    for (int i = 0; i < vecs.size(); i++) begin
      v0 = n_valid;
      e0 = n_err;
      send_frame(vecs[i].cmd, vecs[i].data, vecs[i].chk);
      check($sformatf("vec%0d valid pulse", i), 8'(o_Frame_Valid), 8'(vecs[i].exp_valid));
      check($sformatf("vec%0d error pulse", i), 8'(o_Frame_Error), 8'(vecs[i].exp_error));
      check($sformatf("vec%0d display", i), o_Display_Byte, vecs[i].exp_disp);
      check($sformatf("vec%0d led", i), 8'(o_LED), 8'(vecs[i].exp_led));
      check($sformatf("vec%0d busy", i), 8'(o_Busy), 8'h00);
      idle(2);
      check($sformatf("vec%0d valid count", i), 8'(n_valid - v0), 8'(vecs[i].exp_valid));
      check($sformatf("vec%0d error count", i), 8'(n_err - e0), 8'(vecs[i].exp_error));
    end

    // Timeout: counter reaches TMO-1 fifteen edges after CMD, FSM drops on the next.
    e0 = n_err;
    send_byte(8'hA5);
    send_byte(8'h01);
    check("timeout busy mid-frame", 8'(o_Busy), 8'h01);
    idle(TMO - 1);
    check("timeout no early error", 8'(o_Frame_Error), 8'h00);
    check("timeout busy before expiry", 8'(o_Busy), 8'h01);
    idle(1);
    check("timeout error pulse", 8'(o_Frame_Error), 8'h01);
    check("timeout busy after", 8'(o_Busy), 8'h00);
    check("timeout display kept", o_Display_Byte, 8'hA5);
    check("timeout led kept", 8'(o_LED), 8'h05);
    idle(2);
    check("timeout error count", 8'(n_err - e0), 8'h01);

    // Byte landing on the expiry edge wins over the timeout.
    e0 = n_err;
    v0 = n_valid;
    send_byte(8'hA5);
    send_byte(8'h01);
    idle(TMO - 1);
    send_byte(8'h42);
    check("expiry byte no error", 8'(o_Frame_Error), 8'h00);
`ifdef UART_CMD_CHECKSUM_EN
    check("expiry byte busy", 8'(o_Busy), 8'h01);
    send_byte(8'h43);
`endif
    check("expiry frame valid", 8'(o_Frame_Valid), 8'h01);
    check("expiry frame display", o_Display_Byte, 8'h42);
    idle(2);
    check("expiry error count", 8'(n_err - e0), 8'h00);
    check("expiry valid count", 8'(n_valid - v0), 8'h01);

    // Reset mid-frame discards the partial frame without an error.
    e0 = n_err;
    send_byte(8'hA5);
    send_byte(8'h01);
    i_Rst_L = 1'b0;
    #1;
    check("midreset display", o_Display_Byte, 8'h00);
    check("midreset led", 8'(o_LED), 8'h00);
    check("midreset busy", 8'(o_Busy), 8'h00);
    idle(2);
    i_Rst_L = 1'b1;
    idle(3);
    check("midreset error count", 8'(n_err - e0), 8'h00);
    send_frame(8'h01, 8'h55, 8'h54);
    check("post-reset valid", 8'(o_Frame_Valid), 8'h01);
    check("post-reset display", o_Display_Byte, 8'h55);
    idle(2);

    check("valid and error overlap", 8'(n_both), 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_cmd_ctrl.md
UART_CMD_CTRL -- requirements
Module: uart_cmd_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CLKS, default 250000, meaning the maximum number of idle clocks allowed between bytes of one frame.
REQ-002 SHALL have port i_Clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-003 SHALL have port i_Rst_L, input, 1 bit: asynchronous active-low reset.
REQ-004 SHALL have port i_RX_DV, input, 1 bit: one-clock strobe from the UART receiver marking a valid byte.
REQ-005 SHALL have port i_RX_Byte, input, 8 bits: the received byte, qualified by i_RX_DV.
REQ-006 SHALL have port o_Display_Byte, output, 8 bits: the registered byte driving both seven-segment digits.
REQ-007 SHALL have port o_LED, output, 4 bits: the registered LED pattern.
REQ-008 SHALL have port o_Frame_Valid, output, 1 bit: a one-clock pulse when a frame executes.
REQ-009 SHALL have port o_Frame_Error, output, 1 bit: a one-clock pulse when a frame is rejected.
REQ-010 SHALL have port o_Busy, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-011 Frame format SHALL be SYNC (0xA5), CMD, DATA and, when checksums are enabled, CHK = CMD xor DATA.
REQ-012 FSM states SHALL be IDLE, GET_CMD, GET_DATA and GET_CHK; the FSM SHALL advance only on clocks where i_RX_DV=1.
REQ-013 In IDLE, a byte equal to 0xA5 SHALL move the FSM to GET_CMD; any other byte SHALL be ignored silently, with no error.
REQ-014 GET_CMD SHALL latch CMD and go to GET_DATA; GET_DATA SHALL latch DATA and go to GET_CHK, or go directly to IDLE and execute when checksums are disabled.
REQ-015 GET_CHK SHALL go to IDLE; it SHALL execute on a checksum match and pulse o_Frame_Error on a mismatch.
REQ-016 Execute SHALL support three commands: 0x01 loads o_Display_Byte with DATA; 0x02 loads o_LED with DATA[3:0]; 0x03 clears both o_Display_Byte and o_LED to 0.
REQ-017 Any other CMD value SHALL pulse o_Frame_Error and leave both outputs unchanged.
REQ-018 Latency: the outputs and o_Frame_Valid SHALL update on the same clock edge that samples the final frame byte; there is no separate execute cycle, so no byte can be lost.
REQ-019 o_Frame_Valid and o_Frame_Error SHALL never be high in the same cycle.
REQ-020 The timeout counter SHALL clear on every i_RX_DV and while in IDLE, and SHALL otherwise increment while not in IDLE.
REQ-021 When the counter reaches TIMEOUT_CLKS-1, the FSM SHALL return to IDLE and pulse o_Frame_Error.
REQ-022 If i_RX_DV coincides with timeout expiry, the byte SHALL win: it is processed normally and no timeout error is raised.
REQ-023 A 0xA5 received mid-frame SHALL be treated as ordinary CMD, DATA or CHK data; there is no resynchronisation.
REQ-024 The counter width SHALL be $clog2(TIMEOUT_CLKS), and the counter SHALL never wrap while active.

Reset
REQ-025 While i_Rst_L=0, the block SHALL immediately force state=IDLE, counter=0, o_Display_Byte=0x00, o_LED=0x0, o_Frame_Valid=0, o_Frame_Error=0 and o_Busy=0.
REQ-026 Reset asserted mid-frame SHALL discard the partial frame with no error pulse; deassertion SHALL be synchronised to i_Clk.

Configuration
REQ-027 Macro UART_CMD_CHECKSUM_EN SHALL control the checksum feature.
REQ-028 When UART_CMD_CHECKSUM_EN is defined, the GET_CHK state and the checksum comparison SHALL be present and frames are 4 bytes.
REQ-029 When UART_CMD_CHECKSUM_EN is undefined, GET_CHK SHALL not exist, frames are 3 bytes, and execution occurs on the DATA byte.

Structure
REQ-030 Package uart_cmd_pkg SHALL hold the FSM state enum, the SYNC constant 0xA5 and the command codes 0x01, 0x02 and 0x03.
REQ-031 The timeout counter SHALL be a sub-module, uart_cmd_timer, with ports clear, enable and expired.

Verification
REQ-032 Bytes A5,01,3C,3D -> o_Display_Byte=0x3C and one o_Frame_Valid pulse on the CHK edge (without the macro: A5,01,3C -> the same result on the DATA edge).
REQ-033 Bytes A5,02,F9,FB -> o_LED=0x9 and o_Display_Byte unchanged; then A5,03,00,03 -> both outputs equal 0.
REQ-034 Bytes A5,01,3C,00 (bad CHK) or A5,07,00,07 (unknown CMD) -> one o_Frame_Error pulse, outputs unchanged, FSM in IDLE.
REQ-035 A5 then 01, then a TIMEOUT_CLKS gap (set to 16) -> error pulse at count 15; a byte arriving exactly on the expiry cycle -> no error.
REQ-036 i_Rst_L pulsed low after A5,01 -> outputs 0 and o_Busy=0; then A5,01,55,54 -> o_Display_Byte=0x55.
